// File: rtl/traffic_demand_detector.sv
// Per-approach vehicle demand detection: sensor synchronizer, debounce, request FSM and starvation timer.
// Optional lamp-conflict monitor is built only when TRAFFIC_CONFLICT_MON_EN is defined.
module traffic_demand_detector #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned MAX_WAIT        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sensor,
  input  logic [3:0] green,
  input  logic [3:0] yellow,
  output logic [3:0] req,
  output logic [3:0] starve,
  output logic       conflict
);

  typedef enum logic [1:0] {IDLE, PENDING, SERVED} state_t;

  localparam logic [7:0]  DEB_MAX  = 8'(DEBOUNCE_CYCLES);
  localparam logic [15:0] WAIT_MAX = 16'(MAX_WAIT);

  logic [3:0]  sync1_q, sync1_d;
  logic [3:0]  sync2_q, sync2_d;
  logic [7:0]  deb_q [4];
  logic [7:0]  deb_d [4];
  logic [3:0]  detect_q, detect_d;
  state_t      state_q [4];
  state_t      state_d [4];
  logic [15:0] wait_q [4];
  logic [15:0] wait_d [4];
  logic [3:0]  req_q, req_d;
  logic [3:0]  starve_q, starve_d;

  always_comb begin
    sync1_d  = sensor;
    sync2_d  = sync1_q;
    detect_d = '0;
    req_d    = '0;
    starve_d = '0;
    for (int i = 0; i < 4; i++) begin
      deb_d[i]   = '0;
      state_d[i] = state_q[i];
      wait_d[i]  = '0;

      if (sync2_q[i]) begin
        deb_d[i] = (deb_q[i] == DEB_MAX) ? deb_q[i] : deb_q[i] + 8'd1;
      end
      // detect is registered so the sensor-to-request latency is DEBOUNCE_CYCLES+3 edges
      detect_d[i] = (deb_q[i] == DEB_MAX);

      case (state_q[i])
        IDLE:    if (detect_q[i] && !green[i] && !yellow[i]) state_d[i] = PENDING;
        PENDING: if (green[i]) state_d[i] = SERVED;
        SERVED:  if (!green[i] && !yellow[i]) state_d[i] = IDLE;
        default: state_d[i] = IDLE;
      endcase

      if (state_d[i] == PENDING && state_q[i] == PENDING) begin
        wait_d[i] = (wait_q[i] == WAIT_MAX) ? wait_q[i] : wait_q[i] + 16'd1;
      end

      // outputs follow the next state so req drops on the same edge that enters SERVED
      req_d[i]    = (state_d[i] == PENDING);
      starve_d[i] = (state_d[i] == PENDING) && (wait_d[i] == WAIT_MAX);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      detect_q <= '0;
      req_q    <= '0;
      starve_q <= '0;
      for (int i = 0; i < 4; i++) begin
        deb_q[i]   <= '0;
        state_q[i] <= IDLE;
        wait_q[i]  <= '0;
      end
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      detect_q <= detect_d;
      req_q    <= req_d;
      starve_q <= starve_d;
      for (int i = 0; i < 4; i++) begin
        deb_q[i]   <= deb_d[i];
        state_q[i] <= state_d[i];
        wait_q[i]  <= wait_d[i];
      end
    end
  end

  assign req    = req_q;
  assign starve = starve_q;

`ifdef TRAFFIC_CONFLICT_MON_EN
  logic       conflict_q, conflict_d;
  logic [3:0] lit;

  always_comb begin
    lit = green | yellow;
    // clearing the lowest set bit leaves something only when two or more approaches are lit
    conflict_d = conflict_q | ((lit & (lit - 4'd1)) != 4'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) conflict_q <= 1'b0;
    else       conflict_q <= conflict_d;
  end

  assign conflict = conflict_q;
`else
  assign conflict = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_demand_detector.sv
// Directed bench for traffic_demand_detector with DEBOUNCE_CYCLES=4, MAX_WAIT=16.
module tb_traffic_demand_detector;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sensor, green, yellow;
  logic [3:0] req, starve;
  logic       conflict;
  int         checks = 0;
  int         errors = 0;
  logic [3:0] seen;
  logic       exp_conf;

  traffic_demand_detector #(.DEBOUNCE_CYCLES(4), .MAX_WAIT(16)) dut (
    .clk(clk), .reset(reset), .sensor(sensor), .green(green), .yellow(yellow),
    .req(req), .starve(starve), .conflict(conflict)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse reset, release on a falling edge so the next rising edge is edge 0.
  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    #2;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
`ifdef TRAFFIC_CONFLICT_MON_EN
    exp_conf = 1'b1;
`else
    exp_conf = 1'b0;
`endif
    reset = 1'b1; sensor = '0; green = '0; yellow = '0;
    ticks(2);
    check("reset_req", {12'd0, req}, 16'h0);
    check("reset_starve", {12'd0, starve}, 16'h0);
    check("reset_conflict", {15'd0, conflict}, 16'h0);
    @(negedge clk);
    reset = 1'b0;

    // Sensor 1 held high: request at edge 7
    sensor = 4'b0010;
    ticks(7);
    check("lat_edge6_req", {12'd0, req}, 16'h0);
    tick();
    check("lat_edge7_req", {12'd0, req}, 16'h2);
    check("lat_edge7_starve", {12'd0, starve}, 16'h0);

    // Sensor 2 bounce never qualifies
    sensor = '0;
    do_reset();
    seen = '0;
    sensor = 4'b0100;
    for (int k = 0; k < 3; k++) begin tick(); seen |= req; end
    sensor = 4'b0000;
    tick(); seen |= req;
    sensor = 4'b0100;
    for (int k = 0; k < 3; k++) begin tick(); seen |= req; end
    sensor = 4'b0000;
    for (int k = 0; k < 8; k++) begin tick(); seen |= req; end
    check("bounce_no_req", {12'd0, seen}, 16'h0);

    // Serve approach 0, yellow phase, then re-request
    do_reset();
    sensor = 4'b0001;
    ticks(8);
    check("serve_pending", {12'd0, req}, 16'h1);
    green = 4'b0001;
    tick();
    check("serve_green_drop", {12'd0, req}, 16'h0);
    green = 4'b0000; yellow = 4'b0001;
    ticks(5);
    check("serve_yellow_held", {12'd0, req}, 16'h0);
    yellow = 4'b0000;
    tick();
    check("serve_back_idle", {12'd0, req}, 16'h0);
    tick();
    check("serve_rerequest", {12'd0, req}, 16'h1);

    // Detect ignored while own lamp is lit
    do_reset();
    green = 4'b0001;
    ticks(12);
    check("ignore_green", {12'd0, req}, 16'h0);
    green = 4'b0000;
    tick();
    check("ignore_green_release", {12'd0, req}, 16'h1);

    // Starvation on approach 3; sensor loss does not cancel the request
    sensor = '0;
    do_reset();
    sensor = 4'b1000;
    ticks(8);
    check("starve_pending", {12'd0, req}, 16'h8);
    sensor = 4'b0000;
    ticks(15);
    check("starve_15_flag", {12'd0, starve}, 16'h0);
    check("starve_15_req", {12'd0, req}, 16'h8);
    tick();
    check("starve_16_flag", {12'd0, starve}, 16'h8);
    ticks(3);
    check("starve_held", {12'd0, starve}, 16'h8);
    green = 4'b1000;
    tick();
    check("starve_green_flag", {12'd0, starve}, 16'h0);
    check("starve_green_req", {12'd0, req}, 16'h0);
    green = 4'b0000;

    // All approaches, reset mid-debounce
    do_reset();
    sensor = 4'b1111;
    ticks(4);
    #1 reset = 1'b1;
    #2;
    check("midreset_req", {12'd0, req}, 16'h0);
    check("midreset_starve", {12'd0, starve}, 16'h0);
    @(negedge clk);
    reset = 1'b0;
    ticks(7);
    check("all_edge6_req", {12'd0, req}, 16'h0);
    tick();
    check("all_edge7_req", {12'd0, req}, 16'hF);
    ticks(3);
    check("all_held", {12'd0, req}, 16'hF);

    // Lamp conflict monitor
    sensor = '0;
    do_reset();
    green = 4'b0001; yellow = 4'b0001;
    tick();
    check("conf_same_approach", {15'd0, conflict}, 16'h0);
    green = 4'b0001; yellow = 4'b0100;
    tick();
    check("conf_set", {15'd0, conflict}, {15'd0, exp_conf});
    green = '0; yellow = '0;
    ticks(3);
    check("conf_sticky", {15'd0, conflict}, {15'd0, exp_conf});
    do_reset();
    tick();
    check("conf_cleared", {15'd0, conflict}, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_demand_detector.md
TRAFFIC_DEMAND_DETECTOR -- requirements
Module: traffic_demand_detector

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive synchronized-high cycles needed to qualify a vehicle (range 1..255).
REQ-002 The block SHALL have parameter MAX_WAIT, default 16: pending cycles before the starvation flag asserts (range 1..65535).
REQ-003 The block SHALL have port clk, input, 1 bit: clock; all logic uses its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port sensor, input, 4 bits: raw asynchronous vehicle sensors; bit 0 = north, 1 = east, 2 = south, 3 = west.
REQ-006 The block SHALL have port green, input, 4 bits: green lamp state per approach from the light controller, synchronous to clk, same bit order as sensor.
REQ-007 The block SHALL have port yellow, input, 4 bits: yellow lamp state per approach, synchronous to clk, same bit order.
REQ-008 The block SHALL have port req, output, 4 bits: registered service requests driving controller inputs A (bit 0), B, C, D (bit 3).
REQ-009 The block SHALL have port starve, output, 4 bits: registered per-approach starvation flags.
REQ-010 The block SHALL have port conflict, output, 1 bit: registered sticky lamp-conflict flag.

Function
REQ-011 Each sensor bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 Each approach SHALL have a debounce counter that clears on a synchronized-low cycle, increments on a synchronized-high cycle, and saturates at DEBOUNCE_CYCLES; "detect" SHALL be true while the counter equals DEBOUNCE_CYCLES.
REQ-013 Each approach SHALL run a 3-state FSM (IDLE, PENDING, SERVED); req[i] SHALL be 1 exactly while that approach is in PENDING.
REQ-014 IDLE->PENDING SHALL occur on detect with green[i]=0 and yellow[i]=0; with green[i] or yellow[i] high, detect is ignored and the FSM stays IDLE.
REQ-015 PENDING->SERVED SHALL occur on the first cycle green[i]=1; req[i] deasserts on that same clock edge.
REQ-016 SERVED->IDLE SHALL occur on the first cycle green[i]=0 and yellow[i]=0; a still-present vehicle re-requests from IDLE one cycle later via the existing saturated detect.
REQ-017 Sensor loss while PENDING SHALL NOT cancel the request; the request is held until served.
REQ-018 Latency from the first clk edge sampling sensor[i] high (held high, lamps off) to req[i] high SHALL be exactly DEBOUNCE_CYCLES+3 rising edges.
REQ-019 A per-approach 16-bit wait counter SHALL count cycles in PENDING, saturating at MAX_WAIT; starve[i] SHALL be 1 while the counter equals MAX_WAIT and PENDING is active; the counter clears on leaving PENDING.
REQ-020 The four approaches SHALL operate independently; simultaneous requests on all approaches SHALL all be held.

Reset
REQ-021 Asserting reset at any time SHALL immediately force every FSM to IDLE, clear synchronizers and all counters, and drive req=0, starve=0, and conflict=0.
REQ-022 After reset deasserts, a sensor held high SHALL take the full REQ-018 latency again.

Configuration
REQ-023 With macro TRAFFIC_CONFLICT_MON_EN defined, conflict SHALL set one cycle after any cycle in which more than one approach has green or yellow high, and SHALL stay set until reset.
REQ-024 Without TRAFFIC_CONFLICT_MON_EN, conflict SHALL be tied to 0 and no monitor logic SHALL be instantiated.

Verification (DEBOUNCE_CYCLES=4, MAX_WAIT=16)
REQ-025 The bench SHALL cover: sensor[1] held high from edge 0 with lamps off -> req[1]=1 at edge 7, other req bits 0.
REQ-026 The bench SHALL cover: sensor[2] high for 3 cycles, low for 1, then high for 3 -> req[2] never asserts.
REQ-027 The bench SHALL cover: req[0] pending with green[0] rising -> req[0]=0 on that edge; green[0] falls, yellow[0] pulses for 5 cycles then falls while sensor[0] is held -> req[0]=1 again one cycle after yellow falls.
REQ-028 The bench SHALL cover: req[3] pending for 16 cycles with no green -> starve[3]=1 and stays 1; green[3]=1 -> starve[3]=0 and req[3]=0.
REQ-029 The bench SHALL cover: all four sensors high, then reset pulsed mid-debounce -> req=0, starve=0, and req reasserts 7 edges after reset release.
REQ-030 The bench SHALL cover, with TRAFFIC_CONFLICT_MON_EN defined: green=4'b0001 and yellow=4'b0100 in one cycle -> conflict=1 on the next edge and held until reset; without the macro, conflict stays 0.
